// File: rtl/hs_rr_merge_if.sv
// ----------------------------------------------------------------------------
// hs_rr_merge_if
// Bundle of the source-side and destination-side req/ack signals of the
// round-robin merge.
//   src_req  [NUM_SRC]            level request to each source
//   src_ack  [NUM_SRC]            1-cycle ack from each source
//   src_din  [DATA_WIDTH*NUM_SRC] source words, slice i belongs to source i
//   src_en   [NUM_SRC]            source eligible for selection
//   dst_req                       level request from the destination
//   dst_ack                       1-cycle ack, dst_dout valid with it
//   dst_dout [DATA_WIDTH]         delivered word
//   dst_sel  [SEL_W]              source index that supplied dst_dout
//   err                           1-cycle error pulse
// Modport master is the merge itself; modport slave is its environment.
// ----------------------------------------------------------------------------
interface hs_rr_merge_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SRC    = 2
);
   localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0]            src_req;
   logic [NUM_SRC-1:0]            src_ack;
   logic [DATA_WIDTH*NUM_SRC-1:0] src_din;
   logic [NUM_SRC-1:0]            src_en;
   logic                          dst_req;
   logic                          dst_ack;
   logic [DATA_WIDTH-1:0]         dst_dout;
   logic [SEL_W-1:0]              dst_sel;
   logic                          err;

   modport master (
      output src_req, dst_ack, dst_dout, dst_sel, err,
      input  src_ack, src_din, src_en, dst_req
   );

   modport slave (
      input  src_req, dst_ack, dst_dout, dst_sel, err,
      output src_ack, src_din, src_en, dst_req
   );
endinterface

// File: rtl/hs_rr_merge.sv
// ----------------------------------------------------------------------------
// hs_rr_merge
// Round-robin merge of NUM_SRC req/ack producers onto one req/ack consumer.
// One word is pulled per grant: the selected source is requested, its word is
// captured on its ack, and the word is then handed to the destination.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  hs_rr_merge_if.master (source and destination handshakes, err)
// Parameters:
//   DATA_WIDTH word width, NUM_SRC 2..8 sources,
//   TIMEOUT    WAIT cycles before a silent source is abandoned (0 = never)
// ----------------------------------------------------------------------------
module hs_rr_merge #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SRC    = 2,
   parameter int TIMEOUT    = 64
) (
   input  logic          clk,
   input  logic          rst,
   hs_rr_merge_if.master bus
);
   localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 2);
   localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1'b1);
   localparam logic [SEL_W-1:0]   LAST_RST = SEL_W'(NUM_SRC - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_FULL    = 3'd2,
      ST_DELIVER = 3'd3,
      ST_FLUSH   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [NUM_SRC-1:0]    src_req_q, src_req_d;
   logic                  dst_ack_q, dst_ack_d;
   logic [DATA_WIDTH-1:0] dst_dout_q, dst_dout_d;
   logic [SEL_W-1:0]      dst_sel_q, dst_sel_d;
   logic                  err_q, err_d;
   logic [SEL_W-1:0]      last_q, last_d;
   logic [SEL_W-1:0]      gnt_q, gnt_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic [SEL_W-1:0]      pick_s;
   int                    best_s;
   int                    dist_s;
   logic                  any_en_s;
   logic [DATA_WIDTH-1:0] gnt_word_s;
   logic [NUM_SRC-1:0]    gnt_mask_s;
   logic [NUM_SRC-1:0]    ack_ok_s;
   logic                  gnt_ack_s;
   logic                  stray_s;
   logic                  timeout_hit_s;

   // Round-robin pick: nearest enabled source strictly after the last grant,
   // wrapping; the last-granted source itself has the largest distance.
   always_comb begin
      pick_s = last_q;
      best_s = NUM_SRC + 1;
      dist_s = 0;
      for (int j = 0; j < NUM_SRC; j++) begin
         dist_s = (j > int'(last_q)) ? (j - int'(last_q))
                                     : (j - int'(last_q) + NUM_SRC);
         pick_s = (bus.src_en[j] && (dist_s < best_s)) ? SEL_W'(j) : pick_s;
         best_s = (bus.src_en[j] && (dist_s < best_s)) ? dist_s : best_s;
      end
   end

   // Word offered by the currently granted source.
   always_comb begin
      gnt_word_s = '0;
      for (int j = 0; j < NUM_SRC; j++) begin
         gnt_word_s = (gnt_q == SEL_W'(j)) ? bus.src_din[j*DATA_WIDTH +: DATA_WIDTH]
                                           : gnt_word_s;
      end
   end

   assign any_en_s   = |bus.src_en;
   assign gnt_mask_s = ONE_HOT0 << gnt_q;
   assign gnt_ack_s  = |(bus.src_ack & gnt_mask_s);
   // Only the granted source may ack, and only while waiting; anything else
   // (including a late ack during FLUSH) is discarded and flagged.
   assign ack_ok_s   = (state_q == ST_WAIT) ? gnt_mask_s : '0;
   assign stray_s    = |(bus.src_ack & ~ack_ok_s);
   assign timeout_hit_s = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

   // Next-state and registered-output logic of the grant FSM.
   always_comb begin
      state_d    = state_q;
      src_req_d  = src_req_q;
      dst_ack_d  = 1'b0;
      dst_dout_d = dst_dout_q;
      dst_sel_d  = dst_sel_q;
      err_d      = stray_s;
      last_d     = last_q;
      gnt_d      = gnt_q;
      cnt_d      = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.dst_req && any_en_s) begin
               src_req_d = ONE_HOT0 << pick_s;
               gnt_d     = pick_s;
               last_d    = pick_s;
               cnt_d     = '0;
               state_d   = ST_WAIT;
            end else begin
               src_req_d = '0;
               state_d   = ST_IDLE;
            end
         end

         ST_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (gnt_ack_s) begin
               dst_dout_d = gnt_word_s;
               dst_sel_d  = gnt_q;
               src_req_d  = '0;
               if (bus.dst_req) begin
                  dst_ack_d = 1'b1;
                  state_d   = ST_DELIVER;
               end else begin
                  state_d   = ST_FULL;
               end
            end else if (timeout_hit_s) begin
               // Pointer already moved past gnt_q, so the next grant skips it.
               src_req_d = '0;
               err_d     = 1'b1;
               state_d   = ST_FLUSH;
            end else begin
               state_d   = ST_WAIT;
            end
         end

         ST_FULL: begin
            if (bus.dst_req) begin
               dst_ack_d = 1'b1;
               state_d   = ST_DELIVER;
            end else begin
               state_d   = ST_FULL;
            end
         end

         ST_DELIVER: begin
            if (bus.dst_req && any_en_s) begin
               src_req_d = ONE_HOT0 << pick_s;
               gnt_d     = pick_s;
               last_d    = pick_s;
               cnt_d     = '0;
               state_d   = ST_WAIT;
            end else begin
               state_d   = ST_IDLE;
            end
         end

         ST_FLUSH: begin
            state_d = ST_IDLE;
         end

         default: begin
            src_req_d = '0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aims the pointer so source 0 wins first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         src_req_q  <= '0;
         dst_ack_q  <= 1'b0;
         dst_dout_q <= '0;
         dst_sel_q  <= '0;
         err_q      <= 1'b0;
         last_q     <= LAST_RST;
         gnt_q      <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         src_req_q  <= src_req_d;
         dst_ack_q  <= dst_ack_d;
         dst_dout_q <= dst_dout_d;
         dst_sel_q  <= dst_sel_d;
         err_q      <= err_d;
         last_q     <= last_d;
         gnt_q      <= gnt_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.src_req  = src_req_q;
   assign bus.dst_ack  = dst_ack_q;
   assign bus.dst_dout = dst_dout_q;
   assign bus.dst_sel  = dst_sel_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_hs_rr_merge.sv
// ----------------------------------------------------------------------------
// tb_hs_rr_merge
// Directed bench for hs_rr_merge (2 sources, 32-bit words, timeout 4).
// Source models answer a request with a 1-cycle ack one cycle after seeing it;
// every word they present is pushed to a scoreboard queue and popped when the
// merge acks the destination.
// ----------------------------------------------------------------------------
module tb_hs_rr_merge;
   localparam int DW = 32;
   localparam int NS = 2;
   localparam int TO = 4;

   typedef struct packed {
      logic [7:0]  src;
      logic [31:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   hs_rr_merge_if #(.DATA_WIDTH(DW), .NUM_SRC(NS)) bus ();

   hs_rr_merge #(.DATA_WIDTH(DW), .NUM_SRC(NS), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_total = 0;
   int          n_pass  = 0;
   int          cyc     = 0;
   int          n_dst_ack = 0;
   int          last_ack_cyc = -1;
   bit          chk_period = 1'b0;
   logic        prev_dst_ack = 1'b0;
   logic [NS-1:0] prev_req = '0;
   logic [NS-1:0] pend     = '0;
   logic [NS-1:0] auto_en  = '0;
   int          grant_cnt  = 0;
   int          last_grant = -1;
   bit          seen_req0  = 1'b0;
   bit          watch_err  = 1'b0;
   int          err_cnt    = 0;
   int          next_val [NS];
   exp_t        exp_q [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample outputs #1 after the edge, update the scoreboard and
   // grant tracking, then let the source models drive their acks.
   task automatic tick();
      logic [NS-1:0] rise;
      logic          new_ack;
      exp_t          e;
      @(posedge clk);
      #1;
      cyc++;
      if (bus.dst_ack === 1'b1) begin
         check("dst_ack_back_to_back", 64'(prev_dst_ack), 64'd0);
         check("dst_ack_has_word", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_dout", 64'(bus.dst_dout), 64'(e.val));
            check("sb_sel", 64'(bus.dst_sel), 64'(e.src));
         end
         if (chk_period && last_ack_cyc >= 0)
            check("ack_period", 64'(cyc - last_ack_cyc), 64'd3);
         last_ack_cyc = cyc;
         n_dst_ack++;
      end
      prev_dst_ack = bus.dst_ack;
      check("src_req_onehot0", 64'($onehot0(bus.src_req)), 64'd1);
      if (watch_err && bus.err === 1'b1) err_cnt++;
      rise = bus.src_req & ~prev_req;
      for (int i = 0; i < NS; i++) begin
         if (rise[i]) begin
            grant_cnt++;
            last_grant = i;
         end
      end
      if (bus.src_req[0] === 1'b1) seen_req0 = 1'b1;
      prev_req = bus.src_req;
      for (int i = 0; i < NS; i++) begin
         new_ack = auto_en[i] && bus.src_req[i] && pend[i] && !bus.src_ack[i];
         pend[i] = bus.src_req[i] && !new_ack;
         if (new_ack) begin
            bus.src_din[i*DW +: DW] = 32'(next_val[i]);
            exp_q.push_back('{src: 8'(i), val: 32'(next_val[i])});
            next_val[i]++;
         end
         bus.src_ack[i] = new_ack;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.src_ack = '0;
      pend = '0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic wait_grant(input string tag, input int exp_src);
      int g0;
      int b;
      g0 = grant_cnt;
      b  = 0;
      while (grant_cnt == g0 && b < 20) begin
         tick();
         b++;
      end
      check({tag, "_seen"}, 64'(grant_cnt != g0), 64'd1);
      check(tag, 64'(last_grant), 64'(exp_src));
   endtask

   task automatic drain(input string tag);
      bus.src_en  = '0;
      bus.dst_req = 1'b1;
      repeat (10) tick();
      check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_src_req_idle"}, 64'(bus.src_req), 64'd0);
   endtask

   initial begin
      int k;
      int a0;
      int hc;
      int w0;
      bus.src_ack = '0;
      bus.src_din = '0;
      bus.src_en  = '0;
      bus.dst_req = 1'b0;
      next_val[0] = 0;
      next_val[1] = 100;

      // Reset state
      repeat (2) tick();
      check("rst_src_req", 64'(bus.src_req), 64'd0);
      check("rst_dst_ack", 64'(bus.dst_ack), 64'd0);
      check("rst_dst_dout", 64'(bus.dst_dout), 64'd0);
      check("rst_dst_sel", 64'(bus.dst_sel), 64'd0);
      check("rst_err", 64'(bus.err), 64'd0);
      rst = 1'b0;

      // T1: both sources, consumer always ready -> 0,100,1,101,... every 3 cycles
      auto_en = 2'b11;
      bus.src_en = 2'b11;
      bus.dst_req = 1'b1;
      chk_period = 1'b1;
      last_ack_cyc = -1;
      k = 0;
      tick();
      check("t1_first_grant", 64'(bus.src_req), 64'd1);
      for (int c = 0; c < 23; c++) begin
         tick();
         if (bus.dst_ack === 1'b1) begin
            check("t1_dout", 64'(bus.dst_dout),
                  (k % 2 == 0) ? 64'(k / 2) : 64'(100 + k / 2));
            check("t1_sel", 64'(bus.dst_sel), 64'(k % 2));
            k++;
         end
      end
      check("t1_words", 64'(k), 64'd8);
      chk_period = 1'b0;
      drain("t1");

      // T2: only source 1 enabled from reset, then both
      do_reset();
      next_val[1] = 200;
      seen_req0 = 1'b0;
      bus.src_en = 2'b10;
      bus.dst_req = 1'b1;
      a0 = n_dst_ack;
      repeat (12) tick();
      check("t2_no_src_req0", 64'(seen_req0), 64'd0);
      check("t2_words_flowing", 64'(n_dst_ack > a0), 64'd1);
      bus.src_en = 2'b11;
      wait_grant("t2_next_grant_src0", 0);
      drain("t2");

      // T3: destination not ready -> word held in FULL until dst_req
      next_val[0] = 7;
      bus.src_en = 2'b01;
      bus.dst_req = 1'b1;
      tick();
      bus.src_en = 2'b00;
      bus.dst_req = 1'b0;
      a0 = n_dst_ack;
      repeat (6) tick();
      check("t3_no_ack_while_full", 64'(n_dst_ack), 64'(a0));
      check("t3_src_req_dropped", 64'(bus.src_req), 64'd0);
      bus.dst_req = 1'b1;
      tick();
      check("t3_dst_ack", 64'(bus.dst_ack), 64'd1);
      check("t3_dst_dout", 64'(bus.dst_dout), 64'd7);
      tick();
      check("t3_dst_ack_drop", 64'(bus.dst_ack), 64'd0);

      // T4: source 0 silent -> timeout after 4 cycles, late ack discarded
      do_reset();
      auto_en = 2'b10;
      bus.src_en = 2'b11;
      bus.dst_req = 1'b1;
      a0 = n_dst_ack;
      tick();
      check("t4_grant_src0", 64'(bus.src_req), 64'd1);
      hc = 0;
      while (bus.src_req[0] === 1'b1 && hc < 10) begin
         hc++;
         tick();
      end
      check("t4_req_high_cycles", 64'(hc), 64'd4);
      check("t4_timeout_err", 64'(bus.err), 64'd1);
      check("t4_no_dst_ack", 64'(n_dst_ack), 64'(a0));
      bus.src_ack = 2'b01;
      bus.src_din[DW-1:0] = 32'hDEAD_BEEF;
      tick();
      check("t4_late_ack_err", 64'(bus.err), 64'd1);
      check("t4_dout_unchanged", 64'(bus.dst_dout), 64'd0);
      wait_grant("t4_next_grant_src1", 1);
      check("t4_err_cleared", 64'(bus.err), 64'd0);
      auto_en = 2'b11;
      drain("t4");

      // T5: stray acks while IDLE
      bus.dst_req = 1'b0;
      a0 = n_dst_ack;
      bus.src_ack = 2'b10;
      tick();
      check("t5_stray_err", 64'(bus.err), 64'd1);
      check("t5_stray_no_dst_ack", 64'(bus.dst_ack), 64'd0);
      check("t5_stray_no_req", 64'(bus.src_req), 64'd0);
      tick();
      check("t5_err_one_cycle", 64'(bus.err), 64'd0);
      bus.src_ack = 2'b11;
      tick();
      check("t5_dual_stray_err", 64'(bus.err), 64'd1);
      tick();
      check("t5_dual_err_one_cycle", 64'(bus.err), 64'd0);
      check("t5_no_dst_ack_total", 64'(n_dst_ack), 64'(a0));
      bus.src_en = 2'b11;
      bus.dst_req = 1'b1;
      tick();
      check("t5_still_grants", 64'($onehot(bus.src_req)), 64'd1);
      drain("t5");

      // T6: asynchronous reset mid-WAIT, then long randomised run
      auto_en = 2'b00;
      bus.src_en = 2'b11;
      bus.dst_req = 1'b1;
      repeat (2) tick();
      check("t6_in_wait", 64'($onehot(bus.src_req)), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_src_req", 64'(bus.src_req), 64'd0);
      check("t6_async_dst_dout", 64'(bus.dst_dout), 64'd0);
      bus.src_ack = '0;
      pend = '0;
      repeat (2) tick();
      rst = 1'b0;
      auto_en = 2'b11;
      wait_grant("t6_first_grant_src0", 0);
      watch_err = 1'b1;
      w0 = n_dst_ack;
      for (int c = 0; c < 60000 && (n_dst_ack - w0) < 5000; c++) begin
         bus.dst_req = ($urandom_range(0, 7) != 0);
         bus.src_en  = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         tick();
      end
      check("t6_5000_words", 64'((n_dst_ack - w0) >= 5000), 64'd1);
      drain("t6");
      watch_err = 1'b0;
      check("t6_no_err", 64'(err_cnt), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
